player_state_machine: RTL and testbench
=======================================

# player_state_machine

Per-player action state machine that produces the 4-bit player state consumed by the health/block tracking logic and the renderer. It samples the player's buttons and the collision judge's hit pulse, sequences attack phases, and enters hitstun or blockstun with fixed frame durations. It advances only on a per-frame tick, so all durations are counted in frames. It guarantees that every hit or block yields exactly one fresh entry into state 9 or state 10.

## Interface
- STARTUP, default 5: neutral-attack startup frames (≥1)
- ACTIVE, default 2: neutral-attack active frames (≥1)
- RECOVERY, default 16: neutral-attack recovery frames (≥1)
- DIR_STARTUP, default 4: directional-attack startup frames (≥1)
- DIR_ACTIVE, default 3: directional-attack active frames (≥1)
- DIR_RECOVERY, default 15: directional-attack recovery frames (≥1)
- HITSTUN, default 15: hitstun frames (≥1)
- BLOCKSTUN, default 13: blockstun frames (≥1)
- clk  in  1  system clock; the only clock
- rst  in  1  reset, asynchronous, active-high
- frame_tick  in  1  one-cycle pulse per game frame
- btn_left, btn_right, btn_attack  in  1 each  debounced player buttons, level
- facing_right  in  1  1 = opponent is to the right
- hit_in  in  1  one-cycle pulse from the collision judge: opponent hitbox overlapped this player's hurtbox
- health_zero  in  1  level; this player's health is 0
- state  out  4  current state code
- attack_active  out  1  hitbox enable
- attack_dir  out  1  1 = current attack is directional
- move_dir  out  2  01 = moving right, 10 = moving left, 00 = still

## Operation
- State codes: 0 IDLE, 1 WALK_FWD, 2 WALK_BACK, 3 ATK_STARTUP, 4 ATK_ACTIVE, 5 ATK_RECOVERY, 6 DATK_STARTUP, 7 DATK_ACTIVE, 8 DATK_RECOVERY, 9 HITSTUN, 10 BLOCKSTUN, 11 KO. Codes 12-15 are unused. If one is reached, the block goes to IDLE on the next clock.
- Forward is btn_right when facing_right=1, otherwise btn_left. Back is the opposite button. If both or neither direction is held, there is no direction.
- hit_in is latched into hit_pending on any cycle and consumed at the next frame_tick. hit_pending is cleared on consumption and also whenever it is discarded.
- Evaluation happens only on frame_tick cycles, in this priority order:
  - hit_pending in IDLE or WALK_FWD with back held, or in WALK_BACK: go to BLOCKSTUN.
  - hit_pending in IDLE or WALK_FWD without back held, or in any attack state: go to HITSTUN.
  - hit_pending in HITSTUN or BLOCKSTUN: discarded. The player is invulnerable and the state is unchanged.
  - Timed states (3-10): when timer == 0, advance 3→4→5→0, 6→7→8→0, 9→0, 10→0. Otherwise decrement the timer.
  - IDLE, WALK_FWD, WALK_BACK:
    - btn_attack with forward held → 6.
    - btn_attack otherwise → 3.
    - forward only → 1.
    - back only → 2.
    - else → 0.
- The timer is 5 bits wide and is loaded with duration−1 on entry to each timed state. Each timed state therefore lasts exactly its parameter in frames.
- HITSTUN and BLOCKSTUN always exit to IDLE. The state always leaves 9 or 10 before it can re-enter, so every entry is a state change.
- health_zero has top priority and acts on any cycle, without waiting for frame_tick. It forces KO and clears hit_pending. KO is absorbing until rst.
- Output decodes from the state register:
  - attack_active = 1 in states 4 and 7.
  - attack_dir = 1 in states 6-8.
  - move_dir = direction of travel in states 1 and 2, and 00 otherwise.

## Timing
- Reset values: state=0, timer=0, hit_pending=0, attack_active=0, attack_dir=0, move_dir=00.
- state updates on the clock edge of the frame_tick cycle. The outputs are valid the following cycle, with no extra pipeline.
- If hit_in and frame_tick arrive in the same cycle, the hit is consumed in that same evaluation.
- If hit_in arrives the cycle after a frame_tick, it is held until the next frame_tick.
- Multiple hit_in pulses between ticks collapse into one hit.
- health_zero asserted: state=11 on the next clock edge, regardless of frame_tick.
- rst mid-attack or mid-stun: everything returns to reset values immediately, and any pending hit is lost.
- Frame counts, with default parameters:
  - Neutral attack: 23 frames total, with attack_active high for exactly 2 ticks.
  - Hitstun: 15 ticks in state 9, then IDLE.

## Test plan
- Reset then idle: rst pulse, 10 ticks with no buttons → state=0 throughout, and all outputs 0.
- Neutral attack: btn_attack held for one tick from IDLE, facing_right=1 → state sequence is 3 (5 ticks), 4 (2 ticks, attack_active=1), 5 (16 ticks), then 0.
- Block vs hit: facing_right=1, btn_left held (WALK_BACK), hit_in pulse → state=10 for 13 ticks, then 0. Repeat while in state 4 → state=9 for 15 ticks, with no block.
- Invulnerability: hit_in during HITSTUN frame 3 → state stays 9 and exits on schedule. A hit_in 1 tick after the return to IDLE → state goes 0→9 again, which is a new entry.
- Hit latching: hit_in pulsed 3 cycles after a tick, plus a duplicate pulse 2 cycles later, while IDLE → exactly one HITSTUN entry at the next tick.
- KO and reset: health_zero asserted mid-DATK_ACTIVE between ticks → state=11 on the next clock and stays there through 20 ticks. Then rst → state=0.

Source files
------------

// File: rtl/player_state_machine.sv
// Per-player action state machine. Sequences walking, neutral and directional
// attacks, hitstun and blockstun on the per-frame tick, and forces KO when
// health reaches zero. The outputs are decoded directly from the state register.
//
// state | meaning
// ------+-------------------------------------------------------------
//   0   | IDLE          standing still, accepts buttons
//   1   | WALK_FWD      moving toward opponent
//   2   | WALK_BACK     moving away from opponent (blocks incoming hits)
//   3   | ATK_STARTUP   neutral attack wind-up
//   4   | ATK_ACTIVE    neutral attack hitbox live
//   5   | ATK_RECOVERY  neutral attack cool-down
//   6   | DATK_STARTUP  directional attack wind-up
//   7   | DATK_ACTIVE   directional attack hitbox live
//   8   | DATK_RECOVERY directional attack cool-down
//   9   | HITSTUN       took a hit, invulnerable until exit
//  10   | BLOCKSTUN     blocked a hit, invulnerable until exit
//  11   | KO            health exhausted, absorbing until reset
module player_state_machine #(
    parameter int STARTUP      = 5,
    parameter int ACTIVE       = 2,
    parameter int RECOVERY     = 16,
    parameter int DIR_STARTUP  = 4,
    parameter int DIR_ACTIVE   = 3,
    parameter int DIR_RECOVERY = 15,
    parameter int HITSTUN      = 15,
    parameter int BLOCKSTUN    = 13
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_attack,
    input  logic       facing_right,
    input  logic       hit_in,
    input  logic       health_zero,
    output logic [3:0] state,
    output logic       attack_active,
    output logic       attack_dir,
    output logic [1:0] move_dir
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_WALK_FWD  = 4'd1;
    localparam logic [3:0] S_WALK_BACK = 4'd2;
    localparam logic [3:0] S_ATK_ST    = 4'd3;
    localparam logic [3:0] S_ATK_ACT   = 4'd4;
    localparam logic [3:0] S_ATK_REC   = 4'd5;
    localparam logic [3:0] S_DATK_ST   = 4'd6;
    localparam logic [3:0] S_DATK_ACT  = 4'd7;
    localparam logic [3:0] S_DATK_REC  = 4'd8;
    localparam logic [3:0] S_HITSTUN   = 4'd9;
    localparam logic [3:0] S_BLOCKSTUN = 4'd10;
    localparam logic [3:0] S_KO        = 4'd11;

    // Timer reload values: a timed state lasts (reload + 1) frames.
    localparam logic [4:0] T_ATK_ST   = 5'(STARTUP - 1);
    localparam logic [4:0] T_ATK_ACT  = 5'(ACTIVE - 1);
    localparam logic [4:0] T_ATK_REC  = 5'(RECOVERY - 1);
    localparam logic [4:0] T_DATK_ST  = 5'(DIR_STARTUP - 1);
    localparam logic [4:0] T_DATK_ACT = 5'(DIR_ACTIVE - 1);
    localparam logic [4:0] T_DATK_REC = 5'(DIR_RECOVERY - 1);
    localparam logic [4:0] T_HIT      = 5'(HITSTUN - 1);
    localparam logic [4:0] T_BLOCK    = 5'(BLOCKSTUN - 1);

    logic [3:0] r_state;
    logic [4:0] r_timer;
    logic       r_hit_pending;

    logic [3:0] w_state_nxt;
    logic [4:0] w_timer_nxt;
    logic       w_hit_nxt;
    logic       w_hit;
    logic       w_fwd_btn;
    logic       w_back_btn;
    logic       w_fwd;
    logic       w_back;
    logic       w_in_move;
    logic       w_in_attack;
    logic       w_in_timed;

    // Button mapping relative to the opponent; both or neither means no direction.
    always_comb begin
        w_fwd_btn   = facing_right ? btn_right : btn_left;
        w_back_btn  = facing_right ? btn_left  : btn_right;
        w_fwd       = w_fwd_btn  & ~w_back_btn;
        w_back      = w_back_btn & ~w_fwd_btn;
        w_in_move   = (r_state <= S_WALK_BACK);
        w_in_attack = (r_state >= S_ATK_ST) && (r_state <= S_DATK_REC);
        w_in_timed  = (r_state >= S_ATK_ST) && (r_state <= S_BLOCKSTUN);
        // A hit arriving on the tick cycle itself is consumed in that evaluation.
        w_hit       = r_hit_pending | hit_in;
    end

    // State register: state, frame timer and latched hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_timer       <= 5'd0;
            r_hit_pending <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_timer       <= w_timer_nxt;
            r_hit_pending <= w_hit_nxt;
        end
    end

    // Next-state logic: KO override, illegal-code recovery, then frame evaluation.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_hit_nxt   = w_hit;
        if (health_zero) begin
            w_state_nxt = S_KO;
            w_timer_nxt = 5'd0;
            w_hit_nxt   = 1'b0;
        end else if (r_state > S_KO) begin
            w_state_nxt = S_IDLE;
            w_timer_nxt = 5'd0;
            w_hit_nxt   = 1'b0;
        end else if (r_state == S_KO) begin
            w_hit_nxt   = 1'b0;
        end else if (frame_tick) begin
            // Every tick either consumes or discards the pending hit.
            w_hit_nxt = 1'b0;
            if (w_hit && (((r_state == S_IDLE || r_state == S_WALK_FWD) && w_back)
                          || r_state == S_WALK_BACK)) begin
                w_state_nxt = S_BLOCKSTUN;
                w_timer_nxt = T_BLOCK;
            end else if (w_hit && (w_in_move || w_in_attack)) begin
                w_state_nxt = S_HITSTUN;
                w_timer_nxt = T_HIT;
            end else if (w_in_timed) begin
                // Stun states ignore hits but keep counting so they exit on schedule.
                if (r_timer == 5'd0) begin
                    w_timer_nxt = 5'd0;
                    case (r_state)
                        S_ATK_ST: begin
                            w_state_nxt = S_ATK_ACT;
                            w_timer_nxt = T_ATK_ACT;
                        end
                        S_ATK_ACT: begin
                            w_state_nxt = S_ATK_REC;
                            w_timer_nxt = T_ATK_REC;
                        end
                        S_DATK_ST: begin
                            w_state_nxt = S_DATK_ACT;
                            w_timer_nxt = T_DATK_ACT;
                        end
                        S_DATK_ACT: begin
                            w_state_nxt = S_DATK_REC;
                            w_timer_nxt = T_DATK_REC;
                        end
                        default: w_state_nxt = S_IDLE;
                    endcase
                end else begin
                    w_timer_nxt = r_timer - 5'd1;
                end
            end else begin
                w_timer_nxt = 5'd0;
                if (btn_attack && w_fwd) begin
                    w_state_nxt = S_DATK_ST;
                    w_timer_nxt = T_DATK_ST;
                end else if (btn_attack) begin
                    w_state_nxt = S_ATK_ST;
                    w_timer_nxt = T_ATK_ST;
                end else if (w_fwd) begin
                    w_state_nxt = S_WALK_FWD;
                end else if (w_back) begin
                    w_state_nxt = S_WALK_BACK;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
        end
    end

    // Output decode straight from the state register.
    always_comb begin
        state         = r_state;
        attack_active = (r_state == S_ATK_ACT) || (r_state == S_DATK_ACT);
        attack_dir    = (r_state >= S_DATK_ST) && (r_state <= S_DATK_REC);
        move_dir      = 2'b00;
        if (r_state == S_WALK_FWD) begin
            move_dir = facing_right ? 2'b01 : 2'b10;
        end else if (r_state == S_WALK_BACK) begin
            move_dir = facing_right ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: tb/tb_player_state_machine.sv
// Directed bench for player_state_machine with default frame durations.
module tb_player_state_machine;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       btn_attack = 1'b0;
    logic       facing_right = 1'b1;
    logic       hit_in = 1'b0;
    logic       health_zero = 1'b0;
    logic [3:0] state;
    logic       attack_active;
    logic       attack_dir;
    logic [1:0] move_dir;

    int n_vec = 0;
    int n_err = 0;

    player_state_machine dut (
        .clk          (clk),
        .rst          (rst),
        .frame_tick   (frame_tick),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .btn_attack   (btn_attack),
        .facing_right (facing_right),
        .hit_in       (hit_in),
        .health_zero  (health_zero),
        .state        (state),
        .attack_active(attack_active),
        .attack_dir   (attack_dir),
        .move_dir     (move_dir)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // One frame: tick cycle (optionally with a same-cycle hit), then two quiet cycles.
    task automatic do_tick(input logic with_hit);
        @(negedge clk);
        frame_tick = 1'b1;
        hit_in     = with_hit;
        @(negedge clk);
        frame_tick = 1'b0;
        hit_in     = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_hit();
        @(negedge clk);
        hit_in = 1'b1;
        @(negedge clk);
        hit_in = 1'b0;
    endtask

    // Expect the given state for n consecutive frames, ticking after each check.
    task automatic run(input string tag, input int st, input int n, input int aa);
        for (int i = 0; i < n; i++) begin
            chk(tag, state, st);
            chk({tag, "_aa"}, attack_active, aa);
            do_tick(1'b0);
        end
    endtask

    initial begin
        // Reset then idle
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_state", state, 0);
        chk("rst_aa", attack_active, 0);
        chk("rst_adir", attack_dir, 0);
        chk("rst_mdir", move_dir, 0);
        for (int i = 0; i < 10; i++) begin
            do_tick(1'b0);
            chk("idle_state", state, 0);
            chk("idle_mdir", move_dir, 0);
        end

        // Neutral attack: 5 + 2 + 16 frames, then IDLE
        btn_attack = 1'b1;
        do_tick(1'b0);
        btn_attack = 1'b0;
        chk("atk_adir", attack_dir, 0);
        run("atk_st", 3, 5, 0);
        run("atk_act", 4, 2, 1);
        run("atk_rec", 5, 16, 0);
        chk("atk_done", state, 0);

        // Walking directions and both-held
        facing_right = 1'b0;
        btn_left = 1'b1;
        do_tick(1'b0);
        chk("wfwd_l_state", state, 1);
        chk("wfwd_l_mdir", move_dir, 2'b10);
        btn_right = 1'b1;
        do_tick(1'b0);
        chk("both_state", state, 0);
        btn_right = 1'b0;
        facing_right = 1'b1;

        // Block while walking back
        do_tick(1'b0);
        chk("wback_state", state, 2);
        chk("wback_mdir", move_dir, 2'b10);
        pulse_hit();
        do_tick(1'b0);
        run("block", 10, 13, 0);
        chk("block_done", state, 0);
        btn_left = 1'b0;

        // Hit during ATK_ACTIVE is never blocked, even with back held
        btn_attack = 1'b1;
        do_tick(1'b0);
        btn_attack = 1'b0;
        run("atk2_st", 3, 5, 0);
        chk("atk2_act", state, 4);
        btn_left = 1'b1;
        pulse_hit();
        do_tick(1'b0);
        run("hit_atk", 9, 15, 0);
        chk("hit_atk_done", state, 0);
        btn_left = 1'b0;

        // Invulnerability: hit in frame 3 of HITSTUN is discarded
        pulse_hit();
        do_tick(1'b0);
        run("inv_pre", 9, 3, 0);
        pulse_hit();
        run("inv_post", 9, 12, 0);
        chk("inv_exit", state, 0);
        do_tick(1'b0);
        chk("inv_idle", state, 0);
        pulse_hit();
        do_tick(1'b0);
        run("reentry", 9, 15, 0);
        chk("reentry_done", state, 0);

        // Hit latching: two pulses between ticks collapse into one entry
        @(negedge clk);
        hit_in = 1'b1;
        @(negedge clk);
        hit_in = 1'b0;
        @(negedge clk);
        hit_in = 1'b1;
        @(negedge clk);
        hit_in = 1'b0;
        chk("latch_hold", state, 0);
        do_tick(1'b0);
        run("latch", 9, 15, 0);
        chk("latch_done", state, 0);
        do_tick(1'b0);
        chk("latch_single", state, 0);

        // Hit coinciding with the tick is consumed in that evaluation
        do_tick(1'b1);
        run("same_cyc", 9, 15, 0);
        chk("same_cyc_done", state, 0);

        // Directional attack, then KO between ticks during DATK_ACTIVE
        btn_right = 1'b1;
        btn_attack = 1'b1;
        do_tick(1'b0);
        btn_right = 1'b0;
        btn_attack = 1'b0;
        chk("datk_adir", attack_dir, 1);
        run("datk_st", 6, 4, 0);
        chk("datk_act", state, 7);
        chk("datk_act_aa", attack_active, 1);
        chk("datk_act_adir", attack_dir, 1);
        @(negedge clk);
        health_zero = 1'b1;
        @(negedge clk);
        chk("ko_now", state, 11);
        chk("ko_aa", attack_active, 0);
        health_zero = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) pulse_hit();
            if (i == 8) btn_attack = 1'b1;
            do_tick(1'b0);
            chk("ko_hold", state, 11);
        end
        btn_attack = 1'b0;
        rst = 1'b1;
        #1;
        chk("ko_rst", state, 0);
        @(negedge clk);
        rst = 1'b0;
        do_tick(1'b0);
        chk("post_rst", state, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
